// File: rtl/mp2_bitstream_shifter_pkg.sv
// Shared constants and helpers for the MPEG-2 bitstream shifter and its header decoder.
package mp2_bitstream_shifter_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned BUF_DEPTH = 48;
  localparam int unsigned FILL_W    = 6;
  localparam int unsigned CNT_W     = 16;

  // Shift request encodings, shared with the header decoder.
  typedef enum logic [1:0] {
    SHIFT_NONE  = 2'b00,
    SHIFT_BIT1  = 2'b01,
    SHIFT_BIT16 = 2'b10,
    SHIFT_BIT8  = 2'b11
  } shift_en_e;

  // Number of bits consumed for a given shift request.
  function automatic logic [FILL_W-1:0] shift_amount(input logic [1:0] en);
    case (en)
      SHIFT_BIT1:  return FILL_W'(1);
      SHIFT_BIT16: return FILL_W'(16);
      SHIFT_BIT8:  return FILL_W'(8);
      default:     return FILL_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/mp2_bitstream_shifter_if.sv
// Stream-side and decoder-side signals of the bitstream shifter.
interface mp2_bitstream_shifter_if;
  import mp2_bitstream_shifter_pkg::*;

  logic [WORD_W-1:0] Data_In_I;
  logic              Data_Valid_I;
  logic              Data_Read_O;
  logic              Flush_I;
  logic [1:0]        Shift_En_I;
  logic [WORD_W-1:0] Bitstream_Data_O;
  logic              Bitstream_Byte_Allign_O;
  logic              Bitstream_Valid_O;
  logic [CNT_W-1:0]  Bit_Count_O;
  logic              Underflow_O;

  // Environment side: feeds words, requests shifts.
  modport master (
    output Data_In_I, Data_Valid_I, Flush_I, Shift_En_I,
    input  Data_Read_O, Bitstream_Data_O, Bitstream_Byte_Allign_O,
           Bitstream_Valid_O, Bit_Count_O, Underflow_O
  );

  // Shifter side.
  modport slave (
    input  Data_In_I, Data_Valid_I, Flush_I, Shift_En_I,
    output Data_Read_O, Bitstream_Data_O, Bitstream_Byte_Allign_O,
           Bitstream_Valid_O, Bit_Count_O, Underflow_O
  );

endinterface

// File: rtl/mp2_bitstream_shifter.sv
// 48-bit left-justified bit buffer: pops 16-bit words, presents the next 16 stream bits,
// and consumes 1/8/16 bits per cycle on request.
module mp2_bitstream_shifter
  import mp2_bitstream_shifter_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  mp2_bitstream_shifter_if.slave bs
);

  localparam logic [FILL_W-1:0] FILL_POP_MAX = FILL_W'(BUF_DEPTH - WORD_W);
  localparam logic [FILL_W-1:0] FILL_WORD    = FILL_W'(WORD_W);

  logic [BUF_DEPTH-1:0] buf_q, buf_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 underflow_q, underflow_d;

  logic [FILL_W-1:0]    shamt;
  logic [FILL_W-1:0]    fill_keep;
  logic [BUF_DEPTH-1:0] word_ext;
  logic                 bs_valid;
  logic                 read_c;

  assign bs_valid = (fill_q >= FILL_WORD);
  // A word fits only when at most 32 bits are held; flush and reset block the pop.
  assign read_c   = bs.Data_Valid_I & (fill_q <= FILL_POP_MAX) & ~bs.Flush_I & ~reset;

  assign bs.Data_Read_O             = read_c;
  assign bs.Bitstream_Data_O        = buf_q[BUF_DEPTH-1 -: WORD_W];
  assign bs.Bitstream_Valid_O       = bs_valid;
  assign bs.Bit_Count_O             = cnt_q;
  assign bs.Bitstream_Byte_Allign_O = (cnt_q[2:0] == 3'd0);
  assign bs.Underflow_O             = underflow_q;

  // Barrel datapath: shift out consumed bits, then drop the new word just below the survivors.
  always_comb begin
    shamt       = '0;
    fill_keep   = fill_q;
    word_ext    = '0;
    buf_d       = buf_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    underflow_d = underflow_q;

    if (bs_valid) begin
      shamt = shift_amount(bs.Shift_En_I);
    end else if (bs.Shift_En_I != SHIFT_NONE) begin
      underflow_d = 1'b1;
    end

    fill_keep = fill_q - shamt;
    buf_d     = buf_q << shamt;
    fill_d    = fill_keep;

    if (read_c) begin
      word_ext = {bs.Data_In_I, {(BUF_DEPTH-WORD_W){1'b0}}} >> fill_keep;
      buf_d    = buf_d | word_ext;
      fill_d   = fill_keep + FILL_WORD;
    end

    cnt_d = cnt_q + CNT_W'(shamt);

    if (bs.Flush_I) begin
      buf_d       = '0;
      fill_d      = '0;
      cnt_d       = '0;
      underflow_d = 1'b0;
    end
  end

  // State registers; reset discards buffered bits immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_q       <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_mp2_bitstream_shifter.sv
// Directed bench for mp2_bitstream_shifter with a queue-based scoreboard.
module tb_mp2_bitstream_shifter;

  typedef struct {
    logic        rd;
    logic [15:0] data;
    logic        vld;
    logic        al;
    logic [15:0] cnt;
    logic        uf;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  mp2_bitstream_shifter_if bs();

  mp2_bitstream_shifter dut (
    .clock (clock),
    .reset (reset),
    .bs    (bs)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle's inputs and queue the outputs expected while they are applied.
  task automatic step(input logic rst, input logic fl, input logic dv, input logic [1:0] sh,
                      input logic [15:0] din, input logic rd, input logic [15:0] data,
                      input logic vld, input logic al, input logic [15:0] cnt, input logic uf);
    exp_t e;
    @(posedge clock);
    #2;
    reset           = rst;
    bs.Flush_I      = fl;
    bs.Data_Valid_I = dv;
    bs.Shift_En_I   = sh;
    bs.Data_In_I    = din;
    e.rd = rd; e.data = data; e.vld = vld; e.al = al; e.cnt = cnt; e.uf = uf;
    sb_q.push_back(e);
  endtask

  // Monitor: mid-cycle, compare presented outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("read",  {15'd0, bs.Data_Read_O},             {15'd0, e.rd});
        chk("data",  bs.Bitstream_Data_O,                 e.data);
        chk("valid", {15'd0, bs.Bitstream_Valid_O},       {15'd0, e.vld});
        chk("allign",{15'd0, bs.Bitstream_Byte_Allign_O}, {15'd0, e.al});
        chk("count", bs.Bit_Count_O,                      e.cnt);
        chk("uflow", {15'd0, bs.Underflow_O},             {15'd0, e.uf});
      end
    end
  end

  initial begin
    int waited;
    checks = 0; failures = 0;
    reset = 1'b1;
    bs.Flush_I = 1'b0; bs.Data_Valid_I = 1'b0; bs.Shift_En_I = 2'b00; bs.Data_In_I = 16'h0;

    //    rst fl dv sh     din       rd data     vld al cnt     uf
    step(1, 0, 1, 2'b00, 16'hFFFD, 0, 16'h0000, 0, 1, 16'd0,  0); // held in reset, no pop
    step(0, 0, 1, 2'b00, 16'hFFFD, 1, 16'h0000, 0, 1, 16'd0,  0);
    step(0, 0, 1, 2'b00, 16'h1234, 1, 16'hFFFD, 1, 1, 16'd0,  0);
    step(0, 0, 0, 2'b01, 16'h0000, 0, 16'hFFFD, 1, 1, 16'd0,  0); // fill 32
    step(0, 0, 0, 2'b01, 16'h0000, 0, 16'hFFFA, 1, 0, 16'd1,  0);
    step(0, 0, 0, 2'b01, 16'h0000, 0, 16'hFFF4, 1, 0, 16'd2,  0);
    step(0, 0, 0, 2'b11, 16'h0000, 0, 16'hFFE8, 1, 0, 16'd3,  0);
    step(0, 0, 0, 2'b00, 16'h0000, 0, 16'hE891, 1, 0, 16'd11, 0);
    step(0, 0, 0, 2'b01, 16'h0000, 0, 16'hE891, 1, 0, 16'd11, 0);
    step(0, 0, 0, 2'b01, 16'h0000, 0, 16'hD123, 1, 0, 16'd12, 0);
    step(0, 0, 0, 2'b01, 16'h0000, 0, 16'hA246, 1, 0, 16'd13, 0);
    step(0, 0, 0, 2'b01, 16'h0000, 0, 16'h448D, 1, 0, 16'd14, 0);
    step(0, 0, 0, 2'b01, 16'h0000, 0, 16'h891A, 1, 0, 16'd15, 0);
    step(0, 0, 1, 2'b10, 16'hABCD, 1, 16'h1234, 1, 1, 16'd16, 0); // fill 16: pop + shift 16
    step(0, 0, 1, 2'b00, 16'h5678, 1, 16'hABCD, 1, 1, 16'd32, 0);
    step(0, 0, 1, 2'b00, 16'h9ABC, 1, 16'hABCD, 1, 1, 16'd32, 0);
    step(0, 0, 1, 2'b00, 16'hDEAD, 0, 16'hABCD, 1, 1, 16'd32, 0); // fill 48: no pop
    step(0, 0, 1, 2'b00, 16'hDEAD, 0, 16'hABCD, 1, 1, 16'd32, 0);
    step(0, 0, 1, 2'b10, 16'hDEAD, 0, 16'hABCD, 1, 1, 16'd32, 0);
    step(0, 0, 0, 2'b10, 16'h0000, 0, 16'h5678, 1, 1, 16'd48, 0);
    step(0, 0, 0, 2'b11, 16'h0000, 0, 16'h9ABC, 1, 1, 16'd64, 0);
    step(0, 0, 0, 2'b10, 16'h0000, 0, 16'hBC00, 0, 1, 16'd72, 0); // fill 8: underflow
    step(0, 0, 0, 2'b00, 16'h0000, 0, 16'hBC00, 0, 1, 16'd72, 1);
    step(0, 0, 0, 2'b01, 16'h0000, 0, 16'hBC00, 0, 1, 16'd72, 1);
    step(0, 0, 1, 2'b00, 16'h1357, 1, 16'hBC00, 0, 1, 16'd72, 1); // refill at offset 8
    step(0, 0, 0, 2'b00, 16'h0000, 0, 16'hBC13, 1, 1, 16'd72, 1);
    step(0, 1, 1, 2'b10, 16'hFFFF, 0, 16'hBC13, 1, 1, 16'd72, 1); // flush wins
    step(0, 0, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 1, 16'd0,  0);
    step(0, 0, 1, 2'b00, 16'h0F0F, 1, 16'h0000, 0, 1, 16'd0,  0);
    step(0, 0, 0, 2'b00, 16'h0000, 0, 16'h0F0F, 1, 1, 16'd0,  0);
    step(1, 0, 1, 2'b00, 16'h1111, 0, 16'h0000, 0, 1, 16'd0,  0); // async reset mid-cycle

    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge clock);
      waited++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
